// File: rtl/des_block_sequencer_if.sv
// rtl/des_block_sequencer_if.sv - RAM port and DES core handshake bundle for des_block_sequencer
interface des_block_sequencer_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 64
);
   logic              mem_en;
   logic              mem_wr0;
   logic [ADDR_W-1:0] mem_add0;
   logic [DATA_W-1:0] mem_data0_in;
   logic [DATA_W-1:0] mem_data0_out;
   logic              mem_wr1;
   logic [ADDR_W-1:0] mem_add1;
   logic [DATA_W-1:0] mem_data1_in;
   logic              core_valid;
   logic [DATA_W-1:0] core_data;
   logic              core_ready;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              res_ready;

   modport master (
      output mem_en, mem_wr0, mem_add0, mem_data0_in,
      output mem_wr1, mem_add1, mem_data1_in,
      output core_valid, core_data, res_ready,
      input  mem_data0_out, core_ready, res_valid, res_data
   );

   modport slave (
      input  mem_en, mem_wr0, mem_add0, mem_data0_in,
      input  mem_wr1, mem_add1, mem_data1_in,
      input  core_valid, core_data, res_ready,
      output mem_data0_out, core_ready, res_valid, res_data
   );
endinterface

// File: rtl/des_block_sequencer.sv
// rtl/des_block_sequencer.sv - reads RAM blocks, runs each through the DES core, writes results back
// Optional: DES_SEQ_TIMEOUT_EN adds an 8-bit handshake timeout with sticky o_err.
module des_block_sequencer #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_src_addr,
   input  logic [ADDR_W-1:0] i_dst_addr,
   input  logic [ADDR_W:0]   i_num_blocks,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   des_block_sequencer_if.master bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD      = 3'd1;
   localparam logic [2:0] S_RWAIT   = 3'd2;
   localparam logic [2:0] S_ISSUE   = 3'd3;
   localparam logic [2:0] S_COLLECT = 3'd4;
   localparam logic [2:0] S_WR      = 3'd5;
   localparam logic [2:0] S_FIN     = 3'd6;

   localparam logic [ADDR_W:0] C_MAX_BLOCKS = {1'b1, {ADDR_W{1'b0}}};

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   r_idx;
   logic [DATA_W-1:0] r_block;
   logic [DATA_W-1:0] r_result;
   logic [ADDR_W:0]   w_num_clamp;
   logic [ADDR_W:0]   w_idx_inc;
   logic [ADDR_W-1:0] w_idx_lo;
   logic              w_tmo_hit;

   assign w_num_clamp = (i_num_blocks > C_MAX_BLOCKS) ? C_MAX_BLOCKS : i_num_blocks;
   assign w_idx_inc   = r_idx + 1'b1;
   assign w_idx_lo    = r_idx[ADDR_W-1:0];

   // An empty job passes through RWAIT (no RAM access) so done lands two cycles after start.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (i_start) w_next = (w_num_clamp == '0) ? S_RWAIT : S_RD;
         S_RD:      w_next = S_RWAIT;
         S_RWAIT:   w_next = (r_count == '0) ? S_FIN : S_ISSUE;
         S_ISSUE: begin
            if (bus.core_ready)  w_next = S_COLLECT;
            else if (w_tmo_hit)  w_next = S_FIN;
         end
         S_COLLECT: begin
            if (bus.res_valid)   w_next = S_WR;
            else if (w_tmo_hit)  w_next = S_FIN;
         end
         S_WR:      w_next = (w_idx_inc == r_count) ? S_FIN : S_RD;
         S_FIN:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_src    <= '0;
         r_dst    <= '0;
         r_count  <= '0;
         r_idx    <= '0;
         r_block  <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_src   <= i_src_addr;
                  r_dst   <= i_dst_addr;
                  r_count <= w_num_clamp;
                  r_idx   <= '0;
               end
            end
            S_RWAIT:   r_block <= bus.mem_data0_out;
            S_COLLECT: if (bus.res_valid) r_result <= bus.res_data;
            S_WR:      r_idx <= w_idx_inc;
            default:   ;
         endcase
      end
   end

   // Outputs decode state and registers only, so core/result handshakes never reach the RAM pins.
   assign bus.mem_en       = (r_state == S_RD) || (r_state == S_WR);
   assign bus.mem_wr0      = 1'b1;
   assign bus.mem_add0     = (r_state == S_RD) ? (r_src + w_idx_lo) : '0;
   assign bus.mem_data0_in = '0;
   assign bus.mem_wr1      = (r_state != S_WR);
   assign bus.mem_add1     = (r_state == S_WR) ? (r_dst + w_idx_lo) : '0;
   assign bus.mem_data1_in = (r_state == S_WR) ? r_result : '0;
   assign bus.core_valid   = (r_state == S_ISSUE);
   assign bus.core_data    = (r_state == S_ISSUE) ? r_block : '0;
   assign bus.res_ready    = (r_state == S_COLLECT);
   assign o_busy           = (r_state != S_IDLE) && (r_state != S_FIN);
   assign o_done           = (r_state == S_FIN);

`ifdef DES_SEQ_TIMEOUT_EN
   logic [7:0] r_tmo;
   logic       r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_next != r_state)
            r_tmo <= '0;
         else if ((r_state == S_ISSUE) || (r_state == S_COLLECT))
            r_tmo <= r_tmo + 8'd1;
         if (((r_state == S_ISSUE) || (r_state == S_COLLECT)) && (w_next == S_FIN))
            r_err <= 1'b1;
      end
   end

   assign w_tmo_hit = (r_tmo == 8'hFF);
   assign o_err     = r_err;
`else
   assign w_tmo_hit = 1'b0;
   assign o_err     = 1'b0;
`endif
endmodule

// File: tb/tb_des_block_sequencer.sv
// tb/tb_des_block_sequencer.sv - scoreboard bench for des_block_sequencer with RAM and DES core models
module tb_des_block_sequencer;
   localparam logic [63:0] MASK = 64'hFFFF_FFFF_FFFF_FFFF;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_start;
   logic [5:0] i_src_addr;
   logic [5:0] i_dst_addr;
   logic [6:0] i_num_blocks;
   logic       o_busy;
   logic       o_done;
   logic       o_err;

   des_block_sequencer_if #(.ADDR_W(6), .DATA_W(64)) bus ();

   des_block_sequencer #(.ADDR_W(6), .DATA_W(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_src_addr   (i_src_addr),
      .i_dst_addr   (i_dst_addr),
      .i_num_blocks (i_num_blocks),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          n_wr  = 0;
   int          n_en  = 0;
   logic [63:0] ram [64];
   int          q_addr [$];
   logic [63:0] q_data [$];
   bit          stall_mode = 1'b0;
   bit          no_res     = 1'b0;
   bit          pend       = 1'b0;
   logic [63:0] pend_data  = '0;
   logic        prev_cv    = 1'b0;
   logic        prev_cr    = 1'b0;
   logic [63:0] prev_cd    = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Dual-port RAM: port 1 writes, port 0 registered read.
   always @(posedge clk) begin
      if (bus.mem_en && !bus.mem_wr1) ram[bus.mem_add1] <= bus.mem_data1_in;
      if (bus.mem_en && bus.mem_wr0) bus.mem_data0_out <= ram[bus.mem_add0];
   end

   // DES core stand-in: one block in flight, result = block XOR all-ones.
   always @(posedge clk) begin
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (bus.res_valid && bus.res_ready) pend = 1'b0;
         if (bus.core_valid && bus.core_ready) begin
            pend      = 1'b1;
            pend_data = bus.core_data ^ MASK;
         end
      end
      #1;
      bus.core_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.res_valid  = pend && !no_res && (stall_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.res_data   = pend ? pend_data : '0;
   end

   always @(negedge clk) begin
      if (bus.mem_en) begin
         n_en++;
         check_eq("wr0_high", bus.mem_wr0, 1'b1);
      end
      if (bus.mem_en && !bus.mem_wr1) begin
         n_wr++;
         if (q_addr.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
         end else begin
            check_eq("wr_addr", bus.mem_add1, q_addr.pop_front());
            check_eq("wr_data", bus.mem_data1_in, q_data.pop_front());
         end
      end
      if (rst_n && prev_cv && !prev_cr) begin
         check_eq("cv_hold", bus.core_valid, 1'b1);
         check_eq("cd_hold", bus.core_data, prev_cd);
      end
      prev_cv = bus.core_valid;
      prev_cr = bus.core_ready;
      prev_cd = bus.core_data;
   end

   task automatic run_job(input int src, input int dst, input int num, input int exp_lat, input bit stall);
      int eff;
      int c0;
      int wr0;
      int en0;
      bit got;
      eff = (num > 64) ? 64 : num;
      stall_mode = stall;
      for (int k = 0; k < eff; k++) begin
         q_addr.push_back((dst + k) % 64);
         q_data.push_back(ram[(src + k) % 64] ^ MASK);
      end
      @(negedge clk);
      i_start = 1'b1; i_src_addr = 6'(src); i_dst_addr = 6'(dst); i_num_blocks = 7'(num);
      c0 = cyc; wr0 = n_wr; en0 = n_en;
      @(negedge clk);
      i_start = 1'b0;
      check_eq("busy_after_start", o_busy, 1'b1);
      got = 1'b0;
      for (int t = 0; t < 5000; t++) begin
         if (o_done) begin got = 1'b1; break; end
         @(negedge clk);
      end
      check_eq("done_seen", got, 1'b1);
      if (exp_lat >= 0) check_eq("done_lat", cyc - c0, exp_lat);
      check_eq("busy_at_done", o_busy, 1'b0);
      check_eq("n_writes", n_wr - wr0, eff);
      check_eq("n_mem_en", n_en - en0, 2 * eff);
      check_eq("sb_left", q_addr.size(), 0);
      q_addr.delete(); q_data.delete();
      @(negedge clk);
      check_eq("done_pulse", o_done, 1'b0);
      stall_mode = 1'b0;
   endtask

   task automatic reset_mid_job();
      int wr0;
      bit found;
      for (int k = 0; k < 5; k++) begin
         q_addr.push_back((50 + k) % 64);
         q_data.push_back(ram[(20 + k) % 64] ^ MASK);
      end
      @(negedge clk);
      i_start = 1'b1; i_src_addr = 6'd20; i_dst_addr = 6'd50; i_num_blocks = 7'd5;
      wr0 = n_wr;
      @(negedge clk);
      i_start = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (bus.res_ready && (n_wr - wr0 == 2)) begin found = 1'b1; break; end
         @(negedge clk);
      end
      check_eq("collect_blk2", found, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("rst_busy", o_busy, 1'b0);
      check_eq("rst_res_ready", bus.res_ready, 1'b0);
      check_eq("rst_mem_en", bus.mem_en, 1'b0);
      check_eq("rst_core_valid", bus.core_valid, 1'b0);
      repeat (10) @(negedge clk);
      check_eq("rst_no_more_wr", n_wr - wr0, 2);
      check_eq("rst_sb_left", q_addr.size(), 3);
      q_addr.delete(); q_data.delete();
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_src_addr = '0; i_dst_addr = '0; i_num_blocks = '0;
      bus.core_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0; bus.mem_data0_out = '0;
      for (int a = 0; a < 64; a++) ram[a] = {$urandom, $urandom};

      repeat (2) @(negedge clk);
      check_eq("rst_o_busy", o_busy, 1'b0);
      check_eq("rst_o_done", o_done, 1'b0);
      check_eq("rst_o_err", o_err, 1'b0);
      check_eq("rst_mem_en0", bus.mem_en, 1'b0);
      check_eq("rst_wr0", bus.mem_wr0, 1'b1);
      check_eq("rst_wr1", bus.mem_wr1, 1'b1);
      check_eq("rst_add0", bus.mem_add0, 6'd0);
      check_eq("rst_add1", bus.mem_add1, 6'd0);
      check_eq("rst_d0in", bus.mem_data0_in, 64'd0);
      check_eq("rst_d1in", bus.mem_data1_in, 64'd0);
      check_eq("rst_cv", bus.core_valid, 1'b0);
      check_eq("rst_cd", bus.core_data, 64'd0);
      check_eq("rst_rr", bus.res_ready, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_job(0, 32, 4, 21, 1'b0);
      run_job(62, 62, 3, -1, 1'b1);
      run_job(7, 20, 0, 2, 1'b0);
      run_job(5, 5, 100, 321, 1'b0);
      reset_mid_job();
      run_job(10, 40, 2, 11, 1'b0);
      check_eq("err_default", o_err, 1'b0);

`ifdef DES_SEQ_TIMEOUT_EN
      begin
         int e0;
         int wr0;
         bit seen;
         no_res = 1'b1;
         @(negedge clk);
         i_start = 1'b1; i_src_addr = 6'd0; i_dst_addr = 6'd8; i_num_blocks = 7'd2;
         wr0 = n_wr;
         @(negedge clk);
         i_start = 1'b0;
         seen = 1'b0;
         for (int t = 0; t < 50; t++) begin
            if (bus.res_ready) begin seen = 1'b1; break; end
            @(negedge clk);
         end
         check_eq("tmo_collect", seen, 1'b1);
         e0 = cyc;
         seen = 1'b0;
         for (int t = 0; t < 400; t++) begin
            if (o_done) begin seen = 1'b1; break; end
            @(negedge clk);
         end
         check_eq("tmo_done", seen, 1'b1);
         check_eq("tmo_lat", cyc - e0, 256);
         check_eq("tmo_err", o_err, 1'b1);
         check_eq("tmo_no_wr", n_wr - wr0, 0);
         @(negedge clk);
         check_eq("tmo_err_sticky", o_err, 1'b1);
         rst_n = 1'b0;
         no_res = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         check_eq("tmo_err_clr", o_err, 1'b0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
